serial_mod_detector: RTL and testbench

Parametrised serial divisibility detector. It accepts one bit per valid cycle, forming a binary number that arrives MSB-first or LSB-first. It tracks the running remainder modulo DIVISOR and flags when the number received so far is an exact multiple. It is the general successor to the fixed multiple-of-4 stream detector FSM: divisor, count width and bit order are now configurable, and a valid qualifier and frame clear are added.

---
 rtl/serial_mod_detector.sv | 91 +++++++++
 tb/tb_serial_mod_detector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_mod_detector.sv
// Serial divisibility detector: tracks (number received so far) mod DIVISOR,
// one bit per valid cycle, MSB-first or LSB-first, and flags exact multiples.
module serial_mod_detector #(
   parameter int DIVISOR = 4,
   parameter int REM_W   = $clog2(DIVISOR),
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             x,
   input  logic             clear,
   input  logic             lsb_first,
   output logic             z,
   output logic [REM_W-1:0] rem,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             mode
);

   typedef enum logic {EMPTY, ACTIVE} state_t;

   localparam logic [REM_W:0]   DIV       = (REM_W+1)'(DIVISOR);
   localparam logic [REM_W-1:0] W_ONE     = REM_W'(1);
   localparam logic [REM_W-1:0] W_SECOND  = REM_W'(2 % DIVISOR);

   state_t           state;
   logic [REM_W-1:0] weight;

   logic [REM_W:0]   msb_sum;
   logic [REM_W:0]   lsb_sum;
   logic [REM_W:0]   w_dbl;
   logic [REM_W:0]   msb_red;
   logic [REM_W:0]   lsb_red;
   logic [REM_W:0]   w_red;
   logic [REM_W-1:0] rem_next;
   logic [REM_W-1:0] weight_next;
   logic [CNT_W-1:0] cnt_next;

   // Every intermediate is below 2*DIVISOR, so one conditional subtract
   // brings it back into 0..DIVISOR-1.
   always_comb begin
      msb_sum     = {rem, 1'b0} + (REM_W+1)'(x);
      lsb_sum     = {1'b0, rem} + (x ? {1'b0, weight} : '0);
      w_dbl       = {weight, 1'b0};
      msb_red     = (msb_sum >= DIV) ? msb_sum - DIV : msb_sum;
      lsb_red     = (lsb_sum >= DIV) ? lsb_sum - DIV : lsb_sum;
      w_red       = (w_dbl   >= DIV) ? w_dbl   - DIV : w_dbl;
      rem_next    = mode ? lsb_red[REM_W-1:0] : msb_red[REM_W-1:0];
      weight_next = w_red[REM_W-1:0];
      cnt_next    = (&bit_cnt) ? bit_cnt : bit_cnt + CNT_W'(1);
   end

   // NOTE: all state here is sequential, so every assignment is non-blocking;
   // z is registered from the same next values so it never lags rem.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         rem     <= '0;
         weight  <= W_ONE;
         bit_cnt <= '0;
         mode    <= 1'b0;
         z       <= 1'b0;
      end else if (clear) begin
         mode <= lsb_first;
         if (in_valid) begin
            state   <= ACTIVE;
            rem     <= REM_W'(x);
            weight  <= W_SECOND;
            bit_cnt <= CNT_W'(1);
            z       <= ~x;
         end else begin
            state   <= EMPTY;
            rem     <= '0;
            weight  <= W_ONE;
            bit_cnt <= '0;
            z       <= 1'b0;
         end
      end else if (in_valid) begin
         state   <= ACTIVE;
         rem     <= rem_next;
         bit_cnt <= cnt_next;
         z       <= (rem_next == '0);
         if (mode) weight <= weight_next;
      end
   end

   // state mirrors bit_cnt != 0; it is kept so the EMPTY/ACTIVE intent is explicit.
   logic unused_state;
   assign unused_state = (state == ACTIVE);

endmodule

// File: tb/tb_serial_mod_detector.sv
// Bench for serial_mod_detector: four instances (mod 4, 3, 5, 7 with a 3-bit
// counter) share one stimulus stream and are checked against a bit-queue model.
module tb_serial_mod_detector;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic x = 1'b0;
   logic clear = 1'b0;
   logic lsb_first = 1'b0;

   logic       z4, z3, z5, z7;
   logic       mode4, mode3, mode5, mode7;
   logic [1:0] rem4, rem3;
   logic [2:0] rem5, rem7;
   logic [7:0] cnt4, cnt3, cnt5;
   logic [2:0] cnt7;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_mod_detector #(.DIVISOR(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .clear(clear), .lsb_first(lsb_first), .z(z4), .rem(rem4), .bit_cnt(cnt4), .mode(mode4));
   serial_mod_detector #(.DIVISOR(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .clear(clear), .lsb_first(lsb_first), .z(z3), .rem(rem3), .bit_cnt(cnt3), .mode(mode3));
   serial_mod_detector #(.DIVISOR(5)) u5 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .clear(clear), .lsb_first(lsb_first), .z(z5), .rem(rem5), .bit_cnt(cnt5), .mode(mode5));
   serial_mod_detector #(.DIVISOR(7), .CNT_W(3)) u7 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
      .clear(clear), .lsb_first(lsb_first), .z(z7), .rem(rem7), .bit_cnt(cnt7), .mode(mode7));

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the accepted bits of the current number, oldest first.
   bit m_bits[$];
   bit m_mode = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits.delete();
         m_mode = 1'b0;
      end else if (clear) begin
         m_bits.delete();
         m_mode = lsb_first;
         if (in_valid) m_bits.push_back(x);
      end else if (in_valid) begin
         m_bits.push_back(x);
      end
   end

   // Value of the received number modulo d, evaluated from scratch.
   function automatic int exp_rem(input int d);
      int r = 0;
      int p = 1;
      foreach (m_bits[i]) begin
         if (m_mode) begin
            r = (r + int'(m_bits[i]) * p) % d;
            p = (p * 2) % d;
         end else begin
            r = (r * 2 + int'(m_bits[i])) % d;
         end
      end
      return r;
   endfunction

   task automatic cmp(input string tag, input int d, input int cmax,
                      input int r, input int c, input int zz, input int md);
      int er;
      int ec;
      er = exp_rem(d);
      ec = (m_bits.size() > cmax) ? cmax : m_bits.size();
      check({tag, "_rem"}, r, er);
      check({tag, "_cnt"}, c, ec);
      check({tag, "_z"}, zz, (ec != 0 && er == 0) ? 1 : 0);
      check({tag, "_mode"}, md, int'(m_mode));
   endtask

   always @(negedge clk) begin
      cmp("m4", 4, 255, int'(rem4), int'(cnt4), int'(z4), int'(mode4));
      cmp("m3", 3, 255, int'(rem3), int'(cnt3), int'(z3), int'(mode3));
      cmp("m5", 5, 255, int'(rem5), int'(cnt5), int'(z5), int'(mode5));
      cmp("m7", 7, 7,   int'(rem7), int'(cnt7), int'(z7), int'(mode7));
   end

   // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
   task automatic step(input logic v, input logic b, input logic c, input logic l);
      in_valid  = v;
      x         = b;
      clear     = c;
      lsb_first = l;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic l);
      step(1'b0, 1'b0, 1'b1, l);
   endtask

   logic [3:0] vec4;
   logic [4:0] vec5;
   logic [1:0] exp_r4 [4];
   logic [1:0] exp_r3 [5];
   logic [2:0] exp_r5 [4];
   logic       exp_z4 [4];
   logic       exp_z3 [5];
   logic       exp_z5 [4];
   logic [31:0] pat_v;
   logic [31:0] pat_x;

   initial begin
      #3;
      check("reset_rem", int'(rem4), 0);
      check("reset_cnt", int'(cnt4), 0);
      check("reset_z", int'(z4), 0);
      check("reset_mode", int'(mode4), 0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // MSB-first 1,1,0,0 (12) modulo 4.
      start(1'b0);
      vec4 = 4'b1100;
      exp_r4 = '{2'd1, 2'd3, 2'd2, 2'd0};
      exp_z4 = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vec4[3-i], 1'b0, 1'b0);
         check("d4_msb_rem", int'(rem4), int'(exp_r4[i]));
         check("d4_msb_z", int'(z4), int'(exp_z4[i]));
      end
      check("d4_msb_cnt", int'(cnt4), 4);

      // MSB-first 1,0,0,1 (9) then 1 (19) modulo 3.
      start(1'b0);
      vec5 = 5'b10011;
      exp_r3 = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd1};
      exp_z3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, vec5[4-i], 1'b0, 1'b0);
         check("d3_msb_rem", int'(rem3), int'(exp_r3[i]));
         check("d3_msb_z", int'(z3), int'(exp_z3[i]));
      end

      // LSB-first 0,1,0,1 (10) modulo 5; lsb_first is ignored while accumulating.
      start(1'b1);
      vec4 = 4'b0101;
      exp_r5 = '{3'd0, 3'd2, 3'd2, 3'd0};
      exp_z5 = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vec4[3-i], 1'b0, 1'b0);
         check("d5_lsb_rem", int'(rem5), int'(exp_r5[i]));
         check("d5_lsb_z", int'(z5), int'(exp_z5[i]));
      end
      check("d5_lsb_mode", int'(mode5), 1);

      // Hold with in_valid low, then clear+valid restarting with a 0.
      start(1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         check("hold_rem", int'(rem4), 1);
         check("hold_cnt", int'(cnt4), 1);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("restart_rem", int'(rem4), 0);
      check("restart_cnt", int'(cnt4), 1);
      check("restart_z", int'(z4), 1);

      // Nine ones (511): 3-bit counter saturates, 511 = 7*73.
      start(1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      check("sat_cnt7", int'(cnt7), 7);
      check("sat_rem7", int'(rem7), 0);
      check("sat_z7", int'(z7), 1);
      check("nosat_cnt4", int'(cnt4), 9);
      check("nosat_rem4", int'(rem4), 3);

      // LSB-first ones modulo 4: weight collapses to 0, rem sticks at 3.
      start(1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      check("d4_lsb_rem", int'(rem4), 3);

      // Asynchronous reset mid-number.
      start(1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rem", int'(rem4), 0);
      check("async_cnt", int'(cnt4), 0);
      check("async_z", int'(z4), 0);
      check("async_mode", int'(mode4), 0);
      #4 rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("post_rst_rem", int'(rem4), 1);
      check("post_rst_cnt", int'(cnt4), 1);
      check("post_rst_mode", int'(mode4), 0);

      // Mixed stream with gaps and clears; checked by the model only.
      pat_v = 32'b1101_1110_0111_1011_1101_0110_1111_1011;
      pat_x = 32'b1011_0010_1110_0101_1001_1101_0011_0110;
      for (int i = 0; i < 32; i++)
         step(pat_v[i], pat_x[i], (i % 11) == 10, (i % 22) == 10);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
